// File: rtl/stage_wb_pkg.sv
// Shared constants and state encoding for the write-back stage.
// Optional feature macro: WB_BYPASS_EN (write-through forwarding to the ID read ports).
package stage_wb_pkg;

   localparam int WB_REG_ADDR_W = 4;
   localparam int WB_DATA_W     = 32;
   localparam int WB_RETIRED_W  = 32;

   typedef enum logic {
      WB_ST_INIT = 1'b0,
      WB_ST_RUN  = 1'b1
   } wb_state_t;

endpackage

// File: rtl/regfile_2r1w.sv
// Architectural register array: two combinational read ports, one synchronous write port.
// The array has no reset; the owning stage clears it with a sweep after reset.
module regfile_2r1w #(
   parameter int ADDR_W       = 4,
   parameter int DATA_W       = 32,
   parameter bit R0_HARDWIRED = 1'b1
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [ADDR_W-1:0] rd_addr_a,
   output logic [DATA_W-1:0] rd_data_a,
   input  logic [ADDR_W-1:0] rd_addr_b,
   output logic [DATA_W-1:0] rd_data_b
);

   logic [DATA_W-1:0] mem [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Register 0 is masked at the read side so stray writes to it stay invisible.
   always_comb begin
      rd_data_a = mem[rd_addr_a];
      rd_data_b = mem[rd_addr_b];
      if (R0_HARDWIRED && (rd_addr_a == '0)) begin
         rd_data_a = '0;
      end
      if (R0_HARDWIRED && (rd_addr_b == '0)) begin
         rd_data_b = '0;
      end
   end

endmodule

// File: rtl/stage_wb.sv
// Write-back stage: post-reset register clear sweep, commit logic, retired counter.
// Define WB_BYPASS_EN to forward the committing result to matching ID read ports.
import stage_wb_pkg::*;

module stage_wb #(
   parameter int REG_ADDR_W   = WB_REG_ADDR_W,
   parameter int DATA_W       = WB_DATA_W,
   parameter bit R0_HARDWIRED = 1'b1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic                    stall,
   input  logic                    in_flush,
   input  logic                    in_reg_wr,
   input  logic [REG_ADDR_W-1:0]   in_reg_addr_rd,
   input  logic [DATA_W-1:0]       in_alu_res,
   input  logic [REG_ADDR_W-1:0]   rd_addr_r1,
   input  logic [REG_ADDR_W-1:0]   rd_addr_r2,
   output logic [DATA_W-1:0]       rd_data_r1,
   output logic [DATA_W-1:0]       rd_data_r2,
   output logic                    out_ready,
   output logic                    out_wb_valid,
   output logic [REG_ADDR_W-1:0]   out_wb_addr,
   output logic [DATA_W-1:0]       out_wb_data,
   output logic [WB_RETIRED_W-1:0] out_retired
);

   localparam int NUM_REGS = 2**REG_ADDR_W;
   localparam logic [REG_ADDR_W-1:0] LAST_PTR = REG_ADDR_W'(NUM_REGS - 1);

   wb_state_t             state;
   logic [REG_ADDR_W-1:0] ptr;
   logic                  advance;
   logic                  commit;
   logic                  wr_en;
   logic [REG_ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0]     wr_data;
   logic [DATA_W-1:0]     arr_r1;
   logic [DATA_W-1:0]     arr_r2;

   // The write port is shared: the clear sweep owns it in INIT, commits own it in RUN.
   always_comb begin
      advance = (state == WB_ST_RUN) && en && !stall;
      commit  = advance && in_reg_wr && !in_flush &&
                !(R0_HARDWIRED && (in_reg_addr_rd == '0));
      if (state == WB_ST_INIT) begin
         wr_en   = !rst;
         wr_addr = ptr;
         wr_data = '0;
      end else begin
         wr_en   = commit && !rst;
         wr_addr = in_reg_addr_rd;
         wr_data = in_alu_res;
      end
   end

   regfile_2r1w #(
      .ADDR_W       (REG_ADDR_W),
      .DATA_W       (DATA_W),
      .R0_HARDWIRED (R0_HARDWIRED)
   ) u_regfile (
      .clk       (clk),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .rd_addr_a (rd_addr_r1),
      .rd_data_a (arr_r1),
      .rd_addr_b (rd_addr_r2),
      .rd_data_b (arr_r2)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= WB_ST_INIT;
         ptr          <= '0;
         out_ready    <= 1'b0;
         out_wb_valid <= 1'b0;
         out_wb_addr  <= '0;
         out_wb_data  <= '0;
         out_retired  <= '0;
      end else if (state == WB_ST_INIT) begin
         ptr <= ptr + 1'b1;
         if (ptr == LAST_PTR) begin
            state     <= WB_ST_RUN;
            out_ready <= 1'b1;
         end
      end else if (advance) begin
         out_wb_valid <= commit;
         if (commit) begin
            out_wb_addr <= in_reg_addr_rd;
            out_wb_data <= in_alu_res;
         end
         if (!in_flush) begin
            out_retired <= out_retired + 1'b1;
         end
      end
   end

   // Until the sweep finishes the array may still hold stale data, so reads are forced to 0.
   always_comb begin
      rd_data_r1 = arr_r1;
      rd_data_r2 = arr_r2;
`ifdef WB_BYPASS_EN
      if (commit && (rd_addr_r1 == in_reg_addr_rd)) begin
         rd_data_r1 = in_alu_res;
      end
      if (commit && (rd_addr_r2 == in_reg_addr_rd)) begin
         rd_data_r2 = in_alu_res;
      end
`else
`endif
      if (state == WB_ST_INIT) begin
         rd_data_r1 = '0;
         rd_data_r2 = '0;
      end
   end

endmodule

// File: tb/tb_stage_wb.sv
// Self-checking bench for stage_wb: directed scenarios plus randomized traffic vs. an array model.
// Honors WB_BYPASS_EN when the same macro is defined for the bench.
module tb_stage_wb;
   import stage_wb_pkg::*;

   localparam int AW  = WB_REG_ADDR_W;
   localparam int DW  = WB_DATA_W;
   localparam int NUM = 2**AW;

   logic          clk = 1'b0;
   logic          rst;
   logic          en;
   logic          stall;
   logic          in_flush;
   logic          in_reg_wr;
   logic [AW-1:0] in_reg_addr_rd;
   logic [DW-1:0] in_alu_res;
   logic [AW-1:0] rd_addr_r1;
   logic [AW-1:0] rd_addr_r2;
   logic [DW-1:0] rd_data_r1;
   logic [DW-1:0] rd_data_r2;
   logic          out_ready;
   logic          out_wb_valid;
   logic [AW-1:0] out_wb_addr;
   logic [DW-1:0] out_wb_data;
   logic [31:0]   out_retired;

   int vectors     = 0;
   int miscompares = 0;

   logic [DW-1:0] mRegs [NUM];
   bit            mReady;
   int            mInitLeft;
   bit            mWbValid;
   logic [AW-1:0] mWbAddr;
   logic [DW-1:0] mWbData;
   logic [31:0]   mRetired;

   always #5 clk = ~clk;

   stage_wb dut (
      .clk            (clk),
      .rst            (rst),
      .en             (en),
      .stall          (stall),
      .in_flush       (in_flush),
      .in_reg_wr      (in_reg_wr),
      .in_reg_addr_rd (in_reg_addr_rd),
      .in_alu_res     (in_alu_res),
      .rd_addr_r1     (rd_addr_r1),
      .rd_addr_r2     (rd_addr_r2),
      .rd_data_r1     (rd_data_r1),
      .rd_data_r2     (rd_data_r2),
      .out_ready      (out_ready),
      .out_wb_valid   (out_wb_valid),
      .out_wb_addr    (out_wb_addr),
      .out_wb_data    (out_wb_data),
      .out_retired    (out_retired)
   );

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // What an ID read should return given the current bundle and the architectural state.
   function automatic logic [DW-1:0] expRead(input logic [AW-1:0] a);
      if (!mReady || a == 0) return '0;
`ifdef WB_BYPASS_EN
      if (en && !stall && in_reg_wr && !in_flush && a == in_reg_addr_rd) return in_alu_res;
`endif
      return mRegs[a];
   endfunction

   task automatic modelUpdate();
      if (rst) begin
         mReady    = 0;
         mInitLeft = NUM;
         mWbValid  = 0;
         mWbAddr   = '0;
         mWbData   = '0;
         mRetired  = 0;
      end else if (mInitLeft > 0) begin
         mRegs[NUM - mInitLeft] = '0;
         mInitLeft--;
         if (mInitLeft == 0) mReady = 1;
      end else if (en && !stall) begin
         mWbValid = in_reg_wr && !in_flush && (in_reg_addr_rd != 0);
         if (mWbValid) begin
            mRegs[in_reg_addr_rd] = in_alu_res;
            mWbAddr = in_reg_addr_rd;
            mWbData = in_alu_res;
         end
         if (!in_flush) mRetired = mRetired + 1;
      end
   endtask

   // One clock of stimulus: check comb reads before the edge, registered outputs after it.
   task automatic applyStimulus(input bit r, input bit e, input bit s, input bit f, input bit w,
                                input logic [AW-1:0] ad, input logic [DW-1:0] res,
                                input logic [AW-1:0] a1, input logic [AW-1:0] a2);
      rst = r; en = e; stall = s; in_flush = f; in_reg_wr = w;
      in_reg_addr_rd = ad; in_alu_res = res; rd_addr_r1 = a1; rd_addr_r2 = a2;
      #2;
      if (!r && mInitLeft >= 0) begin
         checkOutput("rd_data_r1", rd_data_r1, expRead(a1));
         checkOutput("rd_data_r2", rd_data_r2, expRead(a2));
      end
      @(posedge clk);
      modelUpdate();
      #1;
      checkOutput("out_ready", {31'd0, out_ready}, {31'd0, mReady});
      checkOutput("out_wb_valid", {31'd0, out_wb_valid}, {31'd0, mWbValid});
      checkOutput("out_wb_addr", 32'(out_wb_addr), 32'(mWbAddr));
      checkOutput("out_wb_data", out_wb_data, mWbData);
      checkOutput("out_retired", out_retired, mRetired);
   endtask

   task automatic idle(input logic [AW-1:0] a1, input logic [AW-1:0] a2);
      applyStimulus(0, 0, 0, 0, 0, '0, '0, a1, a2);
   endtask

   task automatic randomCycle(input bit forceEn);
      applyStimulus(0, forceEn || ($urandom_range(9) != 0), $urandom_range(4) == 0,
                    $urandom_range(4) == 0, $urandom_range(9) < 7, AW'($urandom_range(NUM - 1)),
                    DW'($urandom), AW'($urandom_range(NUM - 1)), AW'($urandom_range(NUM - 1)));
   endtask

   initial begin
      mInitLeft = -1;
      $display("[TB] reset and clear sweep");
      applyStimulus(1, 0, 0, 0, 0, '0, '0, '0, '0);
      for (int i = 0; i < NUM; i++) idle(AW'(i), AW'(NUM - 1 - i));
      for (int i = 0; i < NUM / 2; i++) idle(AW'(2 * i), AW'(2 * i + 1));

      $display("[TB] commit, flush, r0 and stall scenarios");
      applyStimulus(0, 1, 0, 0, 1, AW'(5), 32'hDEADBEEF, AW'(5), AW'(5));
      idle(AW'(5), AW'(0));
      applyStimulus(0, 1, 0, 1, 1, AW'(5), 32'hCAFEF00D, AW'(5), AW'(1));
      idle(AW'(5), AW'(5));
      applyStimulus(0, 1, 0, 0, 1, AW'(0), 32'h00001234, AW'(0), AW'(0));
      idle(AW'(0), AW'(0));
      applyStimulus(0, 1, 1, 0, 1, AW'(3), 32'h00000055, AW'(3), AW'(3));
      idle(AW'(3), AW'(3));
      applyStimulus(0, 1, 0, 0, 1, AW'(3), 32'h00000055, AW'(3), AW'(3));
      idle(AW'(3), AW'(3));

      $display("[TB] same-cycle read of committing register");
      applyStimulus(0, 1, 0, 0, 1, AW'(7), 32'h00001111, AW'(1), AW'(2));
      applyStimulus(0, 1, 0, 0, 1, AW'(7), 32'h0000A5A5, AW'(7), AW'(7));
      idle(AW'(7), AW'(7));

      $display("[TB] randomized traffic");
      for (int i = 0; i < 300; i++) randomCycle(0);
      for (int i = 0; i < NUM / 2; i++) idle(AW'(2 * i), AW'(2 * i + 1));

      $display("[TB] reset mid-run, bundles during sweep are dropped");
      applyStimulus(1, 1, 0, 0, 1, AW'(9), 32'h99999999, '0, '0);
      for (int i = 0; i < NUM; i++) randomCycle(1);
      for (int i = 0; i < NUM / 2; i++) idle(AW'(2 * i), AW'(2 * i + 1));
      for (int i = 0; i < 100; i++) randomCycle(0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
